// File: rtl/track_sensor_conditioner.sv
// Track sensor front end: synchronizes and debounces sensors A and B, then decodes
// complete train passages into single-cycle y pulses with direction and a sticky fault.
module track_sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sensor_a_raw,
   input  logic sensor_b_raw,
   input  logic enable,
   input  logic fault_clr,
   output logic y,
   output logic dir,
   output logic fault
);

   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE, A1, AB, AX, B1, BA, BX, FAULT_WAIT
   } state_t;

   // Bit 1 carries sensor A, bit 0 carries sensor B throughout.
   logic [1:0]       q1_p0;
   logic [1:0]       q2_p1;
   logic [1:0]       deb_p2;
   logic [DEB_W-1:0] deb_cnt_p2 [2];

   state_t           state;
   state_t           state_nxt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             y_nxt;
   logic             dir_nxt;
   logic             fault_set;

   // Stage p0/p1: two-flop synchronizer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q1_p0 <= '0;
         q2_p1 <= '0;
      end else begin
         q1_p0 <= {sensor_a_raw, sensor_b_raw};
         q2_p1 <= q1_p0;
      end
   end

   // Stage p2: debounce, level moves only after DEBOUNCE_CYCLES differing samples in a row
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb_p2 <= '0;
         for (int i = 0; i < 2; i++) deb_cnt_p2[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (q2_p1[i] == deb_p2[i]) begin
               deb_cnt_p2[i] <= '0;
            end else if (deb_cnt_p2[i] == DEB_LAST) begin
               deb_p2[i]     <= q2_p1[i];
               deb_cnt_p2[i] <= '0;
            end else begin
               deb_cnt_p2[i] <= deb_cnt_p2[i] + DEB_W'(1);
            end
         end
      end
   end

   // Stage p3: passage decoder
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      y_nxt     = 1'b0;
      dir_nxt   = dir;
      fault_set = 1'b0;
      unique case (state)
         IDLE: begin
            unique case (deb_p2)
               2'b10:   state_nxt = A1;
               2'b01:   state_nxt = B1;
               2'b11:   begin state_nxt = FAULT_WAIT; fault_set = 1'b1; end
               default: ;
            endcase
         end
         A1: begin
            unique case (deb_p2)
               2'b11:   state_nxt = AB;
               2'b00:   state_nxt = IDLE;
               2'b01:   begin state_nxt = FAULT_WAIT; fault_set = 1'b1; end
               default: ;
            endcase
         end
         AB: begin
            unique case (deb_p2)
               2'b01:   state_nxt = AX;
               2'b10:   state_nxt = A1;
               2'b00:   begin state_nxt = FAULT_WAIT; fault_set = 1'b1; end
               default: ;
            endcase
         end
         AX: begin
            unique case (deb_p2)
               2'b00:   begin state_nxt = IDLE; y_nxt = 1'b1; dir_nxt = 1'b1; end
               2'b11:   state_nxt = AB;
               2'b10:   begin state_nxt = FAULT_WAIT; fault_set = 1'b1; end
               default: ;
            endcase
         end
         B1: begin
            unique case (deb_p2)
               2'b11:   state_nxt = BA;
               2'b00:   state_nxt = IDLE;
               2'b10:   begin state_nxt = FAULT_WAIT; fault_set = 1'b1; end
               default: ;
            endcase
         end
         BA: begin
            unique case (deb_p2)
               2'b10:   state_nxt = BX;
               2'b01:   state_nxt = B1;
               2'b00:   begin state_nxt = FAULT_WAIT; fault_set = 1'b1; end
               default: ;
            endcase
         end
         BX: begin
            unique case (deb_p2)
               2'b00:   begin state_nxt = IDLE; y_nxt = 1'b1; dir_nxt = 1'b0; end
               2'b11:   state_nxt = BA;
               2'b01:   begin state_nxt = FAULT_WAIT; fault_set = 1'b1; end
               default: ;
            endcase
         end
         FAULT_WAIT: begin
            if (deb_p2 == 2'b00) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // A stalled train times out only while no legal move is happening this cycle.
      if (state_nxt == state && state != IDLE && state != FAULT_WAIT && tmo_cnt == TMO_LAST) begin
         state_nxt = FAULT_WAIT;
         fault_set = 1'b1;
      end

      if (!enable) begin
         state_nxt = IDLE;
         y_nxt     = 1'b0;
         dir_nxt   = dir;
         fault_set = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (!enable || state == IDLE || state_nxt != state) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LIMIT) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Stage p4: registered outputs, set beats clear on fault
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y     <= 1'b0;
         dir   <= 1'b0;
         fault <= 1'b0;
      end else begin
         y   <= y_nxt;
         dir <= dir_nxt;
         if (fault_set)      fault <= 1'b1;
         else if (fault_clr) fault <= 1'b0;
      end
   end

endmodule

// File: tb/tb_track_sensor_conditioner.sv
// Directed bench for track_sensor_conditioner: a passage-path reference model checked
// every cycle, plus hand-computed pulse/fault timing and count expectations.
module tb_track_sensor_conditioner;

   localparam int DEB = 4;
   localparam int TMO = 100;

   logic clk;
   logic rst_n;
   logic sensor_a_raw;
   logic sensor_b_raw;
   logic enable;
   logic fault_clr;
   logic y;
   logic dir;
   logic fault;

   int n_cmp;
   int n_bad;
   int cyc;
   bit model_ok;

   int ypulses;
   int last_y_cyc;
   int fault_rise_cyc;
   logic prev_fault;

   // reference model state
   logic m_q1a, m_q1b, m_q2a, m_q2b, m_deba, m_debb;
   logic [DEB-1:0] m_ha, m_hb;
   bit m_busy, m_fwait, m_fwd;
   int m_idx, m_dwell;
   logic m_y, m_dir, m_fault;

   track_sensor_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sensor_a_raw (sensor_a_raw),
      .sensor_b_raw (sensor_b_raw),
      .enable       (enable),
      .fault_clr    (fault_clr),
      .y            (y),
      .dir          (dir),
      .fault        (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sensor pattern at position idx along a passage: forward 00,10,11,01; reverse 00,01,11,10.
   function automatic logic [1:0] pat_at(input bit fwd, input int idx);
      case (idx & 3)
         0:       return 2'b00;
         1:       return fwd ? 2'b10 : 2'b01;
         2:       return 2'b11;
         default: return fwd ? 2'b01 : 2'b10;
      endcase
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: evaluated on each rising edge from the values held before it.
   initial begin
      logic [1:0] pat;
      bit fs;
      logic sa, sb;
      cyc = 0;
      model_ok = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_q1a = 0; m_q1b = 0; m_q2a = 0; m_q2b = 0; m_deba = 0; m_debb = 0;
            m_ha = '0; m_hb = '0;
            m_busy = 0; m_fwait = 0; m_fwd = 0; m_idx = 0; m_dwell = 0;
            m_y = 0; m_dir = 0; m_fault = 0;
            model_ok = 1;
         end else begin
            pat = {m_deba, m_debb};
            fs = 0;
            m_y = 0;
            if (!enable) begin
               m_busy = 0; m_fwait = 0; m_dwell = 0;
            end else if (m_fwait) begin
               if (pat == 2'b00) m_fwait = 0;
            end else if (!m_busy) begin
               if (pat == 2'b10 || pat == 2'b01) begin
                  m_busy = 1; m_fwd = (pat == 2'b10); m_idx = 1; m_dwell = 0;
               end else if (pat == 2'b11) begin
                  m_fwait = 1; fs = 1;
               end
            end else if (pat == pat_at(m_fwd, m_idx)) begin
               m_dwell++;
               if (m_dwell == TMO) begin m_busy = 0; m_fwait = 1; fs = 1; end
            end else if (pat == pat_at(m_fwd, m_idx + 1)) begin
               if (m_idx == 3) begin m_busy = 0; m_y = 1; m_dir = m_fwd; end
               else begin m_idx++; m_dwell = 0; end
            end else if (pat == pat_at(m_fwd, m_idx - 1)) begin
               if (m_idx == 1) m_busy = 0;
               else begin m_idx--; m_dwell = 0; end
            end else begin
               m_busy = 0; m_fwait = 1; fs = 1;
            end
            if (fs) m_fault = 1;
            else if (fault_clr) m_fault = 0;

            sa = m_q2a;
            sb = m_q2b;
            m_ha = {m_ha[DEB-2:0], sa};
            m_hb = {m_hb[DEB-2:0], sb};
            if (m_ha == {DEB{~m_deba}}) m_deba = sa;
            if (m_hb == {DEB{~m_debb}}) m_debb = sb;
            m_q2a = m_q1a; m_q2b = m_q1b;
            m_q1a = sensor_a_raw; m_q1b = sensor_b_raw;
         end
      end
   end

   // Per-cycle comparison and pulse/fault event bookkeeping, away from the active edge.
   initial begin
      ypulses = 0;
      last_y_cyc = -1;
      fault_rise_cyc = -1;
      prev_fault = 0;
      forever begin
         @(negedge clk);
         if (model_ok) begin
            check("y", int'(y), int'(m_y));
            check("dir", int'(dir), int'(m_dir));
            check("fault", int'(fault), int'(m_fault));
            if (y === 1'b1) begin ypulses++; last_y_cyc = cyc; end
            if (fault === 1'b1 && prev_fault !== 1'b1) fault_rise_cyc = cyc;
            prev_fault = fault;
         end
      end
   end

   task automatic hold(input logic a, input logic b, input int n);
      sensor_a_raw = a;
      sensor_b_raw = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic forward_passage();
      hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 20);
   endtask

   initial begin
      int p0;
      int t00;
      int t10;
      rst_n = 0;
      sensor_a_raw = 0;
      sensor_b_raw = 0;
      enable = 1;
      fault_clr = 0;
      n_cmp = 0;
      n_bad = 0;

      repeat (3) @(negedge clk);
      check("reset_y", int'(y), 0);
      check("reset_dir", int'(dir), 0);
      check("reset_fault", int'(fault), 0);
      rst_n = 1;
      hold(0, 0, 10);

      // clean forward passage
      p0 = ypulses;
      hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
      t00 = cyc + 1;
      hold(0, 0, 20);
      check("fwd_pulses", ypulses - p0, 1);
      check("fwd_pulse_edge", last_y_cyc, t00 + 6);
      check("fwd_dir", int'(dir), 1);
      check("fwd_fault", int'(fault), 0);

      // reverse passage
      p0 = ypulses;
      hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20);
      t00 = cyc + 1;
      hold(0, 0, 20);
      check("rev_pulses", ypulses - p0, 1);
      check("rev_pulse_edge", last_y_cyc, t00 + 6);
      check("rev_dir", int'(dir), 0);

      // bounce on A, then backout
      p0 = ypulses;
      for (int i = 0; i < 15; i++) hold((i % 2) == 0, 0, 2);
      hold(0, 0, 20);
      check("bounce_pulses", ypulses - p0, 0);
      check("bounce_fault", int'(fault), 0);
      hold(1, 0, 20); hold(0, 0, 20);
      check("backout_pulses", ypulses - p0, 0);
      check("backout_fault", int'(fault), 0);

      // illegal 00 -> 11 jump, passage while faulted, then clear
      p0 = ypulses;
      t00 = cyc + 1;
      hold(1, 1, 20);
      check("illegal_fault", int'(fault), 1);
      check("illegal_fault_edge", fault_rise_cyc, t00 + 6);
      hold(0, 0, 20);
      check("illegal_pulses", ypulses - p0, 0);
      forward_passage();
      check("faulted_pass_pulses", ypulses - p0, 1);
      check("faulted_pass_fault", int'(fault), 1);
      check("faulted_pass_dir", int'(dir), 1);
      fault_clr = 1;
      @(negedge clk);
      fault_clr = 0;
      check("fault_clr", int'(fault), 0);
      hold(0, 0, 5);

      // stall in A1
      p0 = ypulses;
      t10 = cyc + 1;
      hold(1, 0, 150);
      check("stall_fault", int'(fault), 1);
      check("stall_fault_edge", fault_rise_cyc, t10 + 106);
      hold(0, 0, 20);
      check("stall_pulses", ypulses - p0, 0);

      // reset while in AX
      hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
      check("pre_reset_dir", int'(dir), 1);
      check("pre_reset_fault", int'(fault), 1);
      p0 = ypulses;
      rst_n = 0;
      @(negedge clk);
      check("ax_reset_y", int'(y), 0);
      check("ax_reset_dir", int'(dir), 0);
      check("ax_reset_fault", int'(fault), 0);
      rst_n = 1;
      hold(0, 1, 20); hold(0, 0, 20);
      check("ax_reset_pulses", ypulses - p0, 0);

      // disabled passage
      p0 = ypulses;
      enable = 0;
      forward_passage();
      enable = 1;
      hold(0, 0, 10);
      check("disabled_pulses", ypulses - p0, 0);
      check("disabled_fault", int'(fault), 0);

      // decoding resumes after re-enable
      p0 = ypulses;
      hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20); hold(0, 0, 20);
      check("reenable_pulses", ypulses - p0, 1);
      check("reenable_dir", int'(dir), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
